adaptive_fir_lms: RTL and testbench

ADAPTIVE_FIR_LMS -- requirements
Module: adaptive_fir_lms

---
 rtl/anc_pkg.sv | 41 ++++
 rtl/adaptive_fir_lms_if.sv | 28 ++
 rtl/lms_mac.sv | 60 ++++++
 rtl/adaptive_fir_lms.sv | 157 +++++++++++++++
 tb/tb_adaptive_fir_lms.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/anc_pkg.sv
// Shared definitions for the adaptive LMS FIR: controller states, the
// leaky-LMS shift constant and signed saturation helpers used on the
// weight, accumulator and output paths.
package anc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Leaky LMS subtracts w >>> LEAK_SHIFT from each weight on update.
  localparam int LEAK_SHIFT = 10;

  // DRAIN covers the product stage, the accumulate stage and the
  // registered output saturation, so it counts 0..DRAIN_LAST.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  // Largest signed value representable in w bits (w <= 63).
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in w bits (w <= 63).
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Clamp a 64-bit signed value into the signed range of w bits.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
    if (v > sat_max(w)) begin
      return sat_max(w);
    end else if (v < sat_min(w)) begin
      return sat_min(w);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/adaptive_fir_lms_if.sv
// Sample/error input handshake, result output handshake and status for
// the adaptive LMS FIR. The master drives samples, the slave is the filter.
interface adaptive_fir_lms_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] e_in;
  logic [3:0]           mu_shift;
  logic                 adapt_en;
  logic                 leak_en;
  logic                 w_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] y_out;
  logic                 busy;

  modport master (
    output in_valid, x_in, e_in, mu_shift, adapt_en, leak_en, w_clr, out_ready,
    input  in_ready, out_valid, y_out, busy
  );

  modport slave (
    input  in_valid, x_in, e_in, mu_shift, adapt_en, leak_en, w_clr, out_ready,
    output in_ready, out_valid, y_out, busy
  );
endinterface

// File: rtl/lms_mac.sv
// Two-stage multiply/accumulate for the FIR output: the weight*sample
// product is registered, then shifted down by FRAC and added into a
// saturating accumulator. A third register holds the accumulator
// clamped to the output width.
module lms_mac
  import anc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int WW   = 24,
  parameter int FRAC = 15,
  parameter int ACCW = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic signed [WW-1:0] i_w,
  input  logic signed [DW-1:0] i_x,
  output logic signed [DW-1:0] o_y
);

  localparam int PW = WW + DW;

  logic signed [PW-1:0]   w_prod;
  logic signed [PW-1:0]   r_prod;
  logic                   r_prod_vld;
  logic signed [ACCW-1:0] r_acc;
  logic signed [DW-1:0]   r_sat;
  logic signed [63:0]     w_acc_sum;

  assign w_prod    = PW'(i_w) * PW'(i_x);
  assign w_acc_sum = 64'(r_acc) + (64'(r_prod) >>> FRAC);
  assign o_y       = r_sat;

  // Product stage, accumulate stage and saturated output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
      r_sat      <= '0;
    end else begin
      r_sat <= DW'(sat_to(64'(r_acc), DW));
      if (i_clr) begin
        r_prod     <= '0;
        r_prod_vld <= 1'b0;
        r_acc      <= '0;
      end else begin
        r_prod_vld <= i_en;
        if (i_en) begin
          r_prod <= w_prod;
        end
        if (r_prod_vld) begin
          r_acc <= ACCW'(sat_to(w_acc_sum, ACCW));
        end
      end
    end
  end

endmodule

// File: rtl/adaptive_fir_lms.sv
// Adaptive FIR with LMS (optionally leaky) weight update. One tap is
// processed per cycle: the MAC sees the weight before its update, and
// the updated weight is written back in the same cycle.
module adaptive_fir_lms
  import anc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int WW   = 24,
  parameter int TAPS = 64,
  parameter int FRAC = 15,
  parameter int ACCW = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  adaptive_fir_lms_if.slave  bus
);

  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_t               r_state;
  logic [KW-1:0]        r_k;
  logic [1:0]           r_drain;
  logic                 r_in_ready;
  logic                 r_busy;
  logic                 r_out_valid;
  logic signed [DW-1:0] r_y;
  logic signed [DW-1:0] r_e;
  logic [3:0]           r_mu;
  logic                 r_adapt;
  logic                 r_leak;

  logic signed [WW-1:0] r_w [TAPS];
  logic signed [DW-1:0] r_x [TAPS];

  logic                 w_xfer;
  logic signed [DW-1:0] w_mac_y;
  logic signed [63:0]   w_wk;
  logic signed [63:0]   w_xk;
  logic signed [63:0]   w_ek;
  logic signed [63:0]   w_inc;
  logic signed [63:0]   w_leak;
  logic signed [63:0]   w_wsum;
  logic signed [WW-1:0] w_wnew;

  assign w_xfer = bus.in_valid && r_in_ready;

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.y_out     = r_y;

  assign w_wk   = 64'(r_w[r_k]);
  assign w_xk   = 64'(r_x[r_k]);
  assign w_ek   = 64'(r_e);
  assign w_inc  = (w_ek * w_xk) >>> (FRAC + int'(r_mu));
  assign w_leak = r_leak ? (w_wk >>> LEAK_SHIFT) : 64'sd0;
  assign w_wsum = w_wk + w_inc - w_leak;
  assign w_wnew = WW'(sat_to(w_wsum, WW));

  // Controller: accept a pair, walk the taps, drain the MAC, hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_drain     <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_e         <= '0;
      r_mu        <= '0;
      r_adapt     <= 1'b0;
      r_leak      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_state    <= RUN;
            r_k        <= '0;
            r_e        <= bus.e_in;
            r_mu       <= bus.mu_shift;
            r_adapt    <= bus.adapt_en;
            r_leak     <= bus.leak_en;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          if (r_k == KW'(TAPS - 1)) begin
            r_state <= DRAIN;
            r_drain <= '0;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_state     <= HOLD;
            r_y         <= w_mac_y;
            r_out_valid <= 1'b1;
          end else begin
            r_drain <= r_drain + 2'd1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Delay line shift on acceptance; weight clear in idle; per-tap LMS update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_w[i] <= '0;
        r_x[i] <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_x[0] <= bus.x_in;
        for (int i = 1; i < TAPS; i++) begin
          r_x[i] <= r_x[i-1];
        end
      end else if (r_state == IDLE && bus.w_clr) begin
        for (int i = 0; i < TAPS; i++) begin
          r_w[i] <= '0;
        end
      end
      if (r_state == RUN && r_adapt) begin
        r_w[r_k] <= w_wnew;
      end
    end
  end

  lms_mac #(
    .DW  (DW),
    .WW  (WW),
    .FRAC(FRAC),
    .ACCW(ACCW)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .i_clr(w_xfer),
    .i_en (r_state == RUN),
    .i_w  (r_w[r_k]),
    .i_x  (r_x[r_k]),
    .o_y  (w_mac_y)
  );

endmodule

// File: tb/tb_adaptive_fir_lms.sv
// Self-checking bench for adaptive_fir_lms with TAPS=4. A behavioural
// model (plain arrays and arithmetic) predicts each filter output.
module tb_adaptive_fir_lms;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  longint mw [4];
  longint mx [4];

  adaptive_fir_lms_if #(.DW(16)) bus ();

  adaptive_fir_lms #(
    .DW  (16),
    .WW  (24),
    .TAPS(4),
    .FRAC(15),
    .ACCW(48)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint msat(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mw[i] = 0;
      mx[i] = 0;
    end
  endtask

  task automatic model_clear_weights();
    for (int i = 0; i < 4; i++) mw[i] = 0;
  endtask

  // y = sum of (w*x >>> 15) with the pre-update weights, then LMS update.
  task automatic model_step(input longint x, input longint e, input int mu,
                            input bit adapt, input bit leak, output longint y);
    longint acc;
    for (int i = 3; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = x;
    acc = 0;
    for (int i = 0; i < 4; i++) acc = msat(acc + ((mw[i] * mx[i]) >>> 15), 48);
    y = msat(acc, 16);
    if (adapt) begin
      for (int i = 0; i < 4; i++) begin
        mw[i] = msat(mw[i] + ((e * mx[i]) >>> (15 + mu)) - (leak ? (mw[i] >>> 10) : 0), 24);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // clr_mode: 0 none, 1 w_clr alongside the transfer, 2 w_clr held during processing.
  task automatic send_sample(input logic signed [15:0] x, input logic signed [15:0] e,
                             input logic [3:0] mu, input bit adapt, input bit leak,
                             input int clr_mode, output logic signed [15:0] y, output int lat);
    @(negedge clk);
    bus.x_in     = x;
    bus.e_in     = e;
    bus.mu_shift = mu;
    bus.adapt_en = adapt;
    bus.leak_en  = leak;
    bus.w_clr    = (clr_mode == 1);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.w_clr    = (clr_mode == 2);
    bus.x_in     = 16'($urandom);
    bus.e_in     = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    y = bus.y_out;
    @(negedge clk);
    bus.w_clr     = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.y_out !== 16'sd0) begin n_err++; $display("[TB] FAIL reset_y_out got %0d want 0", bus.y_out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_latency();
    longint exp_y;
    int edges;
    int bad;
    model_step(16384, 0, 0, 1'b0, 1'b0, exp_y);
    @(negedge clk);
    bus.x_in = 16'sd16384; bus.e_in = 16'sd0; bus.mu_shift = 4'd0;
    bus.adapt_en = 1'b0; bus.leak_en = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    edges = 0;
    bad = 0;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    n_cmp++; if (edges != 7) begin n_err++; $display("[TB] FAIL latency got %0d edges want 7", edges); end
    n_cmp++; if (bad != 0) begin n_err++; $display("[TB] FAIL ready_low_while_busy got %0d bad edges want 0", bad); end
    n_cmp++; if (longint'(bus.y_out) !== exp_y) begin n_err++; $display("[TB] FAIL latency_y got %0d want %0d", bus.y_out, exp_y); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL release_to_idle got ready=%b busy=%b valid=%b want 1 0 0", bus.in_ready, bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_basic_adapt();
    logic signed [15:0] y;
    longint exp_y;
    int lat;
    do_reset();
    model_step(16384, 16384, 0, 1'b1, 1'b0, exp_y);
    send_sample(16'sd16384, 16'sd16384, 4'd0, 1'b1, 1'b0, 0, y, lat);
    n_cmp++; if (longint'(y) !== exp_y) begin n_err++; $display("[TB] FAIL adapt_first_y got %0d want %0d", y, exp_y); end
    model_step(16384, 0, 0, 1'b0, 1'b0, exp_y);
    send_sample(16'sd16384, 16'sd0, 4'd0, 1'b0, 1'b0, 0, y, lat);
    n_cmp++; if (y !== 16'sd4096) begin n_err++; $display("[TB] FAIL adapt_second_y got %0d want 4096", y); end
  endtask

  task automatic test_hold();
    longint exp_y;
    logic signed [15:0] y0;
    int edges;
    int bad;
    model_step(-1234, 777, 3, 1'b1, 1'b0, exp_y);
    @(negedge clk);
    bus.x_in = -16'sd1234; bus.e_in = 16'sd777; bus.mu_shift = 4'd3;
    bus.adapt_en = 1'b1; bus.leak_en = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    edges = 0;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    y0 = bus.y_out;
    n_cmp++; if (longint'(y0) !== exp_y) begin n_err++; $display("[TB] FAIL hold_y got %0d want %0d", y0, exp_y); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x_in = 16'($urandom);
      bus.adapt_en = 1'b1;
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.y_out !== y0 || bus.in_ready !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("[TB] FAIL hold_stable got %0d bad cycles want 0", bad); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL hold_release got ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    n_cmp++; if (bus.y_out !== y0) begin n_err++; $display("[TB] FAIL hold_y_kept got %0d want %0d", bus.y_out, y0); end
  endtask

  task automatic test_random();
    logic signed [15:0] x, e, y;
    logic [3:0] mu;
    bit adapt, leak;
    longint exp_y;
    int lat;
    for (int i = 0; i < 24; i++) begin
      x = 16'($urandom);
      e = 16'($urandom);
      mu = 4'($urandom_range(1, 15));
      adapt = 1'($urandom);
      leak = 1'($urandom);
      model_step(longint'(x), longint'(e), int'(mu), adapt, leak, exp_y);
      send_sample(x, e, mu, adapt, leak, 0, y, lat);
      n_cmp++; if (longint'(y) !== exp_y) begin n_err++; $display("[TB] FAIL random_y[%0d] got %0d want %0d", i, y, exp_y); end
      n_cmp++; if (lat != 7) begin n_err++; $display("[TB] FAIL random_latency[%0d] got %0d want 7", i, lat); end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] y;
    longint exp_y;
    int lat;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      model_step(32767, 32767, 0, 1'b1, 1'b0, exp_y);
      send_sample(16'sd32767, 16'sd32767, 4'd0, 1'b1, 1'b0, 0, y, lat);
      n_cmp++; if (longint'(y) !== exp_y) begin n_err++; $display("[TB] FAIL sat_y[%0d] got %0d want %0d", i, y, exp_y); end
    end
    n_cmp++; if (y !== 16'sd32767) begin n_err++; $display("[TB] FAIL sat_y_clamp got %0d want 32767", y); end
    n_cmp++; if (dut.r_w[0] !== 24'sd8388607) begin n_err++; $display("[TB] FAIL sat_w0 got %0d want 8388607", dut.r_w[0]); end
  endtask

  task automatic test_reset_mid_run();
    logic signed [15:0] x, y;
    longint exp_y;
    int lat;
    int bad;
    for (int i = 0; i < 3; i++) begin
      x = 16'($urandom);
      model_step(longint'(x), 20000, 1, 1'b1, 1'b0, exp_y);
      send_sample(x, 16'sd20000, 4'd1, 1'b1, 1'b0, 0, y, lat);
    end
    @(negedge clk);
    bus.x_in = 16'sd12345; bus.e_in = 16'sd30000; bus.mu_shift = 4'd0;
    bus.adapt_en = 1'b1; bus.leak_en = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL midrun_reset got ready=%b valid=%b busy=%b want 1 0 0", bus.in_ready, bus.out_valid, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("[TB] FAIL midrun_no_output got %0d valid cycles want 0", bad); end
    for (int i = 0; i < 4; i++) begin
      x = 16'($urandom_range(1000, 32767));
      model_step(longint'(x), 0, 0, 1'b0, 1'b0, exp_y);
      send_sample(x, 16'sd0, 4'd0, 1'b0, 1'b0, 0, y, lat);
      n_cmp++; if (longint'(y) !== exp_y) begin n_err++; $display("[TB] FAIL midrun_zero_w[%0d] got %0d want %0d", i, y, exp_y); end
    end
  endtask

  task automatic test_wclr();
    logic signed [15:0] x, y;
    longint exp_y;
    int lat;
    for (int i = 0; i < 3; i++) begin
      x = 16'($urandom_range(4000, 30000));
      model_step(longint'(x), 25000, 1, 1'b1, 1'b0, exp_y);
      send_sample(x, 16'sd25000, 4'd1, 1'b1, 1'b0, 0, y, lat);
    end
    @(negedge clk);
    bus.w_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.w_clr = 1'b0;
    model_clear_weights();
    x = 16'sd20000;
    model_step(longint'(x), 0, 0, 1'b0, 1'b0, exp_y);
    send_sample(x, 16'sd0, 4'd0, 1'b0, 1'b0, 0, y, lat);
    n_cmp++; if (longint'(y) !== exp_y) begin n_err++; $display("[TB] FAIL wclr_idle got %0d want %0d", y, exp_y); end
    for (int i = 0; i < 2; i++) begin
      x = 16'($urandom_range(4000, 30000));
      model_step(longint'(x), -25000, 1, 1'b1, 1'b1, exp_y);
      send_sample(x, -16'sd25000, 4'd1, 1'b1, 1'b1, 0, y, lat);
    end
    x = 16'sd15000;
    model_step(longint'(x), 0, 0, 1'b0, 1'b0, exp_y);
    send_sample(x, 16'sd0, 4'd0, 1'b0, 1'b0, 2, y, lat);
    n_cmp++; if (longint'(y) !== exp_y) begin n_err++; $display("[TB] FAIL wclr_during_run got %0d want %0d", y, exp_y); end
    x = 16'sd9000;
    model_step(longint'(x), 18000, 2, 1'b1, 1'b0, exp_y);
    send_sample(x, 16'sd18000, 4'd2, 1'b1, 1'b0, 1, y, lat);
    n_cmp++; if (longint'(y) !== exp_y) begin n_err++; $display("[TB] FAIL wclr_with_xfer got %0d want %0d", y, exp_y); end
    x = 16'sd11000;
    model_step(longint'(x), 0, 0, 1'b0, 1'b0, exp_y);
    send_sample(x, 16'sd0, 4'd0, 1'b0, 1'b0, 0, y, lat);
    n_cmp++; if (longint'(y) !== exp_y) begin n_err++; $display("[TB] FAIL wclr_xfer_kept_w got %0d want %0d", y, exp_y); end
  endtask

  // Test sequence.
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_in = '0;
    bus.e_in = '0;
    bus.mu_shift = '0;
    bus.adapt_en = 1'b0;
    bus.leak_en = 1'b0;
    bus.w_clr = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    test_reset();
    test_latency();
    test_basic_adapt();
    test_hold();
    test_random();
    test_saturation();
    test_reset_mid_run();
    test_wclr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
